alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - four-state single-issue controller for a 16-bit ALU.
// Optional illegal-opcode trap outputs are enabled by defining ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  rs_addr,
  output logic [2:0]  rt_addr,
  input  logic [15:0] rf_rdata1,
  input  logic [15:0] rf_rdata2,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  input  logic [15:0] alu_out,
  input  logic        alu_branch,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        branch_taken,
  output logic [15:0] branch_off,
  output logic [15:0] retired_cnt,
  output logic        busy
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_trap,
  output logic        illegal_sticky
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_op;
  logic [2:0]  r_rd;
  logic [2:0]  r_rs;
  logic [2:0]  r_rt;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [15:0] r_res;
  logic        r_br;
  logic [15:0] r_cnt;
  logic        w_legal;
  logic        w_is_branch;
  logic        w_retire;
  logic        w_unused;

  // The two low instruction bits carry no field.
  assign w_unused = ^instr[1:0];

  assign w_is_branch = (r_op >= 5'd20) && (r_op <= 5'd22);
  assign w_legal     = (r_op <= 5'd13) || w_is_branch;
  assign w_retire    = (r_state == S_WB) && w_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 5'd0;
      r_rd    <= 3'd0;
      r_rs    <= 3'd0;
      r_rt    <= 3'd0;
      r_opa   <= 16'd0;
      r_opb   <= 16'd0;
      r_res   <= 16'd0;
      r_br    <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && instr_valid) begin
        r_op <= instr[15:11];
        r_rd <= instr[10:8];
        r_rs <= instr[7:5];
        r_rt <= instr[4:2];
      end
      if (r_state == S_DECODE) begin
        r_opa <= rf_rdata1;
        r_opb <= rf_rdata2;
      end
      if (r_state == S_EXEC) begin
        r_res <= alu_out;
        r_br  <= alu_branch;
      end
      if (w_retire) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic r_sticky;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if ((r_state == S_WB) && !w_legal) begin
      r_sticky <= 1'b1;
    end
  end

  assign illegal_trap   = (r_state == S_WB) && !w_legal;
  assign illegal_sticky = r_sticky;
`endif

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = ~instr_ready;
  assign rs_addr     = r_rs;
  assign rt_addr     = r_rt;
  assign wb_addr     = r_rd;
  assign retired_cnt = r_cnt;

  always_comb begin
    w_next       = r_state;
    alu_op       = 5'd0;
    alu_op1      = 16'd0;
    alu_op2      = 16'd0;
    wb_en        = 1'b0;
    wb_data      = 16'd0;
    branch_taken = 1'b0;
    branch_off   = 16'd0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next  = S_WB;
        alu_op  = w_legal ? r_op : 5'd0;
        alu_op1 = r_opa;
        alu_op2 = r_opb;
      end
      S_WB: begin
        w_next = S_IDLE;
        if (w_is_branch) begin
          branch_taken = r_br;
          branch_off   = {{13{r_rd[2]}}, r_rd};
        end else if (w_legal) begin
          wb_en   = 1'b1;
          wb_data = r_res;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'd0;
  logic [2:0]  rs_addr, rt_addr;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic [4:0]  alu_op;
  logic [15:0] alu_op1, alu_op2, alu_out;
  logic        alu_branch = 1'b0;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        branch_taken;
  logic [15:0] branch_off;
  logic [15:0] retired_cnt;
  logic        busy;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic        illegal_trap, illegal_sticky;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wb_cnt = 0;
  int br_cnt = 0;
  logic [18:0] wb_q[$];
  logic [15:0] rf [8];

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_out(alu_out), .alu_branch(alu_branch),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .branch_taken(branch_taken), .branch_off(branch_off),
    .retired_cnt(retired_cnt), .busy(busy)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    , .illegal_trap(illegal_trap), .illegal_sticky(illegal_sticky)
`endif
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rs_addr];
  assign rf_rdata2 = rf[rt_addr];
  assign alu_out   = (alu_op == 5'd1) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      wb_cnt++;
      wb_q.push_back({wb_addr, wb_data});
    end
    if (branch_taken === 1'b1) br_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 2'b00};
  endfunction

  // Presents one instruction in IDLE and leaves the bench at the negedge of the DECODE cycle.
  task automatic issue(input logic [15:0] ins);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'd0;
  endtask

  int hs_cyc [3];
  int hs_n;
  int idx;
  bit taken;
  int wb_before;
  logic [15:0] seq [3];

  initial begin
    rf[0] = 16'd0;  rf[1] = 16'd5;  rf[2] = 16'd7;  rf[3] = 16'd100;
    rf[4] = 16'd0;  rf[5] = 16'd0;  rf[6] = 16'd0;  rf[7] = 16'd0;

    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_wb_en", wb_en, 0);
    @(negedge clk);
    reset = 1'b0;

    // add r3 = r1 + r2
    issue(mk(5'd0, 3'd3, 3'd1, 3'd2));
    check("add_dec_busy", busy, 1);
    check("add_dec_rs", rs_addr, 1);
    check("add_dec_rt", rt_addr, 2);
    check("add_dec_alu_op1", alu_op1, 0);
    @(negedge clk);
    check("add_ex_op", alu_op, 0);
    check("add_ex_op1", alu_op1, 5);
    check("add_ex_op2", alu_op2, 7);
    check("add_ex_wb_en", wb_en, 0);
    @(negedge clk);
    check("add_wb_en", wb_en, 1);
    check("add_wb_addr", wb_addr, 3);
    check("add_wb_data", wb_data, 12);
    check("add_wb_br", branch_taken, 0);
    @(negedge clk);
    check("add_post_ready", instr_ready, 1);
    check("add_post_wb_en", wb_en, 0);
    check("add_post_wb_data", wb_data, 0);
    check("add_cnt", retired_cnt, 1);

    // sub r4 = r2 - r1
    issue(mk(5'd1, 3'd4, 3'd2, 3'd1));
    @(negedge clk);
    check("sub_ex_op", alu_op, 1);
    @(negedge clk);
    check("sub_wb_data", wb_data, 2);
    check("sub_wb_addr", wb_addr, 4);
    @(negedge clk);
    check("sub_cnt", retired_cnt, 2);

    // beq taken, rd=6 -> offset -2
    alu_branch = 1'b1;
    issue(mk(5'd22, 3'd6, 3'd1, 3'd1));
    @(negedge clk);
    check("beq_ex_op", alu_op, 22);
    @(negedge clk);
    check("beq_t_taken", branch_taken, 1);
    check("beq_t_off", branch_off, 16'hFFFE);
    check("beq_t_wb_en", wb_en, 0);
    @(negedge clk);
    check("beq_t_post_taken", branch_taken, 0);
    check("beq_t_post_off", branch_off, 0);
    check("beq_t_cnt", retired_cnt, 3);

    alu_branch = 1'b0;
    issue(mk(5'd22, 3'd6, 3'd1, 3'd2));
    @(negedge clk);
    @(negedge clk);
    check("beq_nt_taken", branch_taken, 0);
    check("beq_nt_off", branch_off, 16'hFFFE);
    check("beq_nt_wb_en", wb_en, 0);
    @(negedge clk);
    check("beq_nt_cnt", retired_cnt, 4);

    // illegal opcode 31
    wb_before = wb_cnt;
    issue(mk(5'd31, 3'd2, 3'd1, 3'd2));
    @(negedge clk);
    check("ill_ex_op", alu_op, 0);
    @(negedge clk);
    check("ill_wb_en", wb_en, 0);
    check("ill_wb_br", branch_taken, 0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("ill_trap", illegal_trap, 1);
    check("ill_sticky_wb", illegal_sticky, 0);
`endif
    @(negedge clk);
    check("ill_cnt", retired_cnt, 4);
    check("ill_no_wb", wb_cnt - wb_before, 0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("ill_trap_clear", illegal_trap, 0);
    check("ill_sticky", illegal_sticky, 1);
`endif

    // three back-to-back instructions with instr_valid held high
    seq[0] = mk(5'd0, 3'd5, 3'd1, 3'd2);
    seq[1] = mk(5'd1, 3'd6, 3'd2, 3'd1);
    seq[2] = mk(5'd0, 3'd7, 3'd3, 3'd1);
    wb_q.delete();
    wb_before = wb_cnt;
    hs_n = 0; idx = 0; taken = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = seq[0];
    for (int k = 0; k < 20; k++) begin
      if (taken) begin
        taken = 0;
        idx++;
        if (idx < 3) instr = seq[idx];
        else begin
          instr_valid = 1'b0;
          instr = 16'd0;
        end
      end
      if (instr_valid && instr_ready) begin
        hs_cyc[hs_n] = cyc;
        hs_n++;
        taken = 1;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("b2b_hs_count", hs_n, 3);
    check("b2b_gap01", hs_cyc[1] - hs_cyc[0], 4);
    check("b2b_gap12", hs_cyc[2] - hs_cyc[1], 4);
    check("b2b_wb_count", wb_cnt - wb_before, 3);
    check("b2b_wb0", wb_q.size() > 0 ? wb_q[0] : 19'h7FFFF, {3'd5, 16'd12});
    check("b2b_wb1", wb_q.size() > 1 ? wb_q[1] : 19'h7FFFF, {3'd6, 16'd2});
    check("b2b_wb2", wb_q.size() > 2 ? wb_q[2] : 19'h7FFFF, {3'd7, 16'd105});
    check("b2b_cnt", retired_cnt, 7);

    // reset during EXEC aborts the instruction
    wb_before = wb_cnt;
    issue(mk(5'd0, 3'd3, 3'd1, 3'd2));
    @(negedge clk);
    check("rx_in_exec", busy, 1);
    reset = 1'b1;
    #1;
    check("rx_ready", instr_ready, 1);
    check("rx_cnt", retired_cnt, 0);
    check("rx_alu_op1", alu_op1, 0);
    @(negedge clk);
    @(negedge clk);
    check("rx_no_wb", wb_cnt - wb_before, 0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("rx_sticky", illegal_sticky, 0);
`endif
    reset = 1'b0;
    instr_valid = 1'b1;
    instr = mk(5'd0, 3'd1, 3'd1, 3'd2);
    @(negedge clk);
    instr_valid = 1'b0;
    check("rx_first_edge", busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("rx_after_wb", wb_data, 12);
    @(negedge clk);
    check("rx_after_cnt", retired_cnt, 1);

    // counter wrap from 16'hFFFF
    @(negedge clk);
    force dut.r_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_cnt;
    @(negedge clk);
    check("wrap_preload", retired_cnt, 16'hFFFF);
    issue(mk(5'd2, 3'd2, 3'd1, 3'd2));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wrap_cnt", retired_cnt, 16'h0000);
    check("br_pulses", br_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
